// File: rtl/inverse_output_stage_if.sv
// inverse_output_stage_if
//   Bundles the kernel-side capture bus and the row-stream handshake of the
//   inverse output stage.
//   slave  : view taken by inverse_output_stage (captures matrices, drives rows)
//   master : view taken by the kernel / row consumer side
//   Signals:
//     matIn, matInVld, opCntIn, perMatIn, errorIn : kernel result and metadata
//     inReady                                     : stage can accept a final-pass matrix
//     rowOut, rowIdx, rowVld, rowLast, errorOut,
//     satOut                                      : streamed inverse row and status
//     rowReady                                    : consumer accepts the row
//     overrun                                     : sticky dropped-matrix flag
interface inverse_output_stage_if #(
  parameter int MAT_SIZE   = 5,
  parameter int DATWIDTH   = 64,
  parameter int MAT_DWIDTH = 46
);
  localparam int CW = $clog2(MAT_SIZE) + 1;

  logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] matIn;
  logic                                            matInVld;
  logic [CW-1:0]                                   opCntIn;
  logic [MAT_SIZE-1:0][CW-1:0]                     perMatIn;
  logic                                            errorIn;
  logic                                            inReady;

  logic [MAT_SIZE-1:0][MAT_DWIDTH-1:0]             rowOut;
  logic [CW-1:0]                                   rowIdx;
  logic                                            rowVld;
  logic                                            rowReady;
  logic                                            rowLast;
  logic                                            errorOut;
  logic                                            satOut;
  logic                                            overrun;

  modport slave (
    input  matIn, matInVld, opCntIn, perMatIn, errorIn, rowReady,
    output inReady, rowOut, rowIdx, rowVld, rowLast, errorOut, satOut, overrun
  );

  modport master (
    output matIn, matInVld, opCntIn, perMatIn, errorIn, rowReady,
    input  inReady, rowOut, rowIdx, rowVld, rowLast, errorOut, satOut, overrun
  );
endinterface

// File: rtl/inverse_output_stage.sv
// inverse_output_stage
//   Final stage of the fixed-point matrix inversion pipeline. Captures the
//   kernel result only on the last column pass (opCntIn == MAT_SIZE), undoes
//   the pivot permutation at capture, converts each element from the
//   DATWIDTH/DAT_FACTIONBITS format to MAT_DWIDTH/MAT_FACTIONBITS with
//   saturation, and streams the inverse one row per rowVld/rowReady handshake.
//   Ports:
//     clk   : rising-edge clock
//     reset : synchronous, active-high
//     bus   : inverse_output_stage_if.slave (capture bus + row stream)
//   Build option:
//     INV_OUT_ROUND_EN : round half-up before the shift; when undefined the
//                        conversion truncates toward -inf.
//
//   state  | meaning
//   IDLE   | waiting for a final-pass matrix, inReady = 1
//   LOAD   | one cycle: convert row 0 into the output register
//   STREAM | rowVld = 1, advance one row per handshake until rowLast
module inverse_output_stage #(
  parameter int MAT_SIZE        = 5,
  parameter int DATWIDTH        = 64,
  parameter int DAT_FACTIONBITS = 63,
  parameter int MAT_DWIDTH      = 46,
  parameter int MAT_FACTIONBITS = 14
) (
  input logic                   clk,
  input logic                   reset,
  inverse_output_stage_if.slave bus
);

  localparam int CW    = $clog2(MAT_SIZE) + 1;
  localparam int SHIFT = DAT_FACTIONBITS - MAT_FACTIONBITS;
  // One extra bit beyond the wider format absorbs the rounding carry.
  localparam int WW    = ((DATWIDTH > MAT_DWIDTH) ? DATWIDTH : MAT_DWIDTH) + 1;

  localparam logic [MAT_DWIDTH-1:0] OUT_MAX = {1'b0, {(MAT_DWIDTH-1){1'b1}}};
  localparam logic [MAT_DWIDTH-1:0] OUT_MIN = {1'b1, {(MAT_DWIDTH-1){1'b0}}};
  localparam logic signed [WW-1:0]  SAT_HI  =
    $signed({{(WW-MAT_DWIDTH+1){1'b0}}, {(MAT_DWIDTH-1){1'b1}}});
  localparam logic signed [WW-1:0]  SAT_LO  =
    $signed({{(WW-MAT_DWIDTH+1){1'b1}}, {(MAT_DWIDTH-1){1'b0}}});

`ifdef INV_OUT_ROUND_EN
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [WW-1:0] RND_ADD =
    (SHIFT > 0) ? $signed(WW'(1) << RND_SH) : '0;
`endif

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  typedef logic [MAT_SIZE-1:0][MAT_SIZE-1:0][DATWIDTH-1:0] mat_t;
  typedef logic [MAT_SIZE-1:0][DATWIDTH-1:0]               in_row_t;
  typedef logic [MAT_SIZE-1:0][MAT_DWIDTH-1:0]             out_row_t;

  logic [1:0]    state_q,    state_d;
  mat_t          mat_q;
  logic          err_q,      err_d;
  logic [CW-1:0] row_cnt_q,  row_cnt_d;
  out_row_t      row_out_q,  row_out_d;
  logic [CW-1:0] row_idx_q,  row_idx_d;
  logic          row_vld_q,  row_vld_d;
  logic          row_last_q, row_last_d;
  logic          err_out_q,  err_out_d;
  logic          sat_q,      sat_d;
  logic          overrun_q,  overrun_d;

  logic          capture;
  logic          handshake;
  logic          load_mat;
  logic          emit_row;
  mat_t          perm_mat;
  in_row_t       cur_row;
  out_row_t      conv_row;
  logic          conv_sat;
  logic [MAT_DWIDTH:0] conv_res;

  // Returns {saturated, value}.
  function automatic logic [MAT_DWIDTH:0] conv_elem(input logic [DATWIDTH-1:0] x);
    logic signed [WW-1:0] ext;
    logic signed [WW-1:0] sh;
    ext = $signed({{(WW-DATWIDTH){x[DATWIDTH-1]}}, x});
`ifdef INV_OUT_ROUND_EN
    ext = ext + RND_ADD;
`endif
    sh = ext >>> SHIFT;
    if (sh > SAT_HI) begin
      return {1'b1, OUT_MAX};
    end else if (sh < SAT_LO) begin
      return {1'b1, OUT_MIN};
    end else begin
      return {1'b0, sh[MAT_DWIDTH-1:0]};
    end
  endfunction

  assign capture   = bus.matInVld && (bus.opCntIn == CW'(MAT_SIZE));
  assign handshake = row_vld_q && bus.rowReady;

  // Column c of the kernel result lands in buffer column perMatIn[c].
  // Compare-based scatter keeps out-of-range permutation entries harmless.
  always_comb begin
    perm_mat = '0;
    for (int r = 0; r < MAT_SIZE; r++) begin
      for (int c = 0; c < MAT_SIZE; c++) begin
        for (int d = 0; d < MAT_SIZE; d++) begin
          if (bus.perMatIn[c] == CW'(d)) begin
            perm_mat[r][d] = bus.matIn[r][c];
          end
        end
      end
    end
  end

  always_comb begin
    cur_row = '0;
    for (int r = 0; r < MAT_SIZE; r++) begin
      if (row_cnt_q == CW'(r)) begin
        cur_row = mat_q[r];
      end
    end
  end

  always_comb begin
    conv_row = '0;
    conv_sat = 1'b0;
    conv_res = '0;
    for (int c = 0; c < MAT_SIZE; c++) begin
      conv_res    = conv_elem(cur_row[c]);
      conv_row[c] = conv_res[MAT_DWIDTH-1:0];
      conv_sat    = conv_sat | conv_res[MAT_DWIDTH];
    end
  end

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    row_cnt_d  = row_cnt_q;
    row_out_d  = row_out_q;
    row_idx_d  = row_idx_q;
    row_vld_d  = row_vld_q;
    row_last_d = row_last_q;
    err_out_d  = err_out_q;
    sat_d      = sat_q;
    overrun_d  = overrun_q;
    load_mat   = 1'b0;
    emit_row   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (capture) begin
          state_d   = ST_LOAD;
          err_d     = bus.errorIn;
          row_cnt_d = '0;
          load_mat  = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d  = ST_STREAM;
        emit_row = 1'b1;
      end
      ST_STREAM: begin
        if (handshake) begin
          if (row_last_q) begin
            state_d    = ST_IDLE;
            row_vld_d  = 1'b0;
            row_last_d = 1'b0;
          end else begin
            emit_row = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A final-pass matrix that cannot be taken is dropped and flagged.
    if (capture && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    if (emit_row) begin
      row_vld_d  = 1'b1;
      row_idx_d  = row_cnt_q;
      row_last_d = (row_cnt_q == CW'(MAT_SIZE - 1));
      row_cnt_d  = row_cnt_q + CW'(1);
      if (err_q) begin
        row_out_d = '0;
        sat_d     = 1'b0;
        err_out_d = 1'b1;
      end else begin
        row_out_d = conv_row;
        sat_d     = conv_sat;
        err_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      err_q      <= 1'b0;
      row_cnt_q  <= '0;
      row_out_q  <= '0;
      row_idx_q  <= '0;
      row_vld_q  <= 1'b0;
      row_last_q <= 1'b0;
      err_out_q  <= 1'b0;
      sat_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      row_cnt_q  <= row_cnt_d;
      row_out_q  <= row_out_d;
      row_idx_q  <= row_idx_d;
      row_vld_q  <= row_vld_d;
      row_last_q <= row_last_d;
      err_out_q  <= err_out_d;
      sat_q      <= sat_d;
      overrun_q  <= overrun_d;
    end
  end

  // Matrix buffer is only read after a capture, so it needs no reset.
  always_ff @(posedge clk) begin
    if (load_mat) begin
      mat_q <= perm_mat;
    end
  end

  assign bus.inReady  = (state_q == ST_IDLE);
  assign bus.rowOut   = row_out_q;
  assign bus.rowIdx   = row_idx_q;
  assign bus.rowVld   = row_vld_q;
  assign bus.rowLast  = row_last_q;
  assign bus.errorOut = err_out_q;
  assign bus.satOut   = sat_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_inverse_output_stage.sv
module tb_inverse_output_stage;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int OW = 16;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inverse_output_stage_if #(.MAT_SIZE(N), .DATWIDTH(DW), .MAT_DWIDTH(OW)) bus ();

  inverse_output_stage #(
    .MAT_SIZE(N), .DATWIDTH(DW), .DAT_FACTIONBITS(20),
    .MAT_DWIDTH(OW), .MAT_FACTIONBITS(14)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0][N-1:0][DW-1:0] m;
  logic [N-1:0][CW-1:0] perm_ident;
  logic [N-1:0][CW-1:0] perm_201;

`ifdef INV_OUT_ROUND_EN
  localparam logic [47:0] ROUND_ROW0 = 48'h7FFF_FFFF_0002;
`else
  localparam logic [47:0] ROUND_ROW0 = 48'h7FFF_FFFE_0001;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_row(input string tag, input logic [47:0] row, input logic [CW-1:0] idx,
                         input logic last, input logic err, input logic sat);
    chk({tag, ".vld"},  64'(bus.rowVld),   64'(1'b1));
    chk({tag, ".out"},  64'(bus.rowOut),   64'(row));
    chk({tag, ".idx"},  64'(bus.rowIdx),   64'(idx));
    chk({tag, ".last"}, 64'(bus.rowLast),  64'(last));
    chk({tag, ".err"},  64'(bus.errorOut), 64'(err));
    chk({tag, ".sat"},  64'(bus.satOut),   64'(sat));
  endtask

  // Called at a negedge; presents a matrix for exactly one rising edge.
  task automatic send(input logic [N-1:0][CW-1:0] perm, input logic [CW-1:0] op, input logic err);
    bus.matIn    = m;
    bus.perMatIn = perm;
    bus.opCntIn  = op;
    bus.errorIn  = err;
    bus.matInVld = 1'b1;
    @(negedge clk);
    bus.matInVld = 1'b0;
  endtask

  initial begin
    perm_ident   = {3'd2, 3'd1, 3'd0};
    perm_201     = {3'd1, 3'd0, 3'd2};
    reset        = 1'b1;
    bus.matIn    = '0;
    bus.matInVld = 1'b0;
    bus.opCntIn  = '0;
    bus.perMatIn = '0;
    bus.errorIn  = 1'b0;
    bus.rowReady = 1'b0;
    m            = '0;

    repeat (2) @(negedge clk);
    chk("rst.inReady", 64'(bus.inReady),  64'd1);
    chk("rst.rowVld",  64'(bus.rowVld),   64'd0);
    chk("rst.rowOut",  64'(bus.rowOut),   64'd0);
    chk("rst.rowIdx",  64'(bus.rowIdx),   64'd0);
    chk("rst.rowLast", 64'(bus.rowLast),  64'd0);
    chk("rst.errOut",  64'(bus.errorOut), 64'd0);
    chk("rst.satOut",  64'(bus.satOut),   64'd0);
    chk("rst.overrun", 64'(bus.overrun),  64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Permutation: identity * 2^20 with perMatIn = {2,0,1}
    bus.rowReady = 1'b1;
    m = '0;
    m[0][0] = 32'h0010_0000;
    m[1][1] = 32'h0010_0000;
    m[2][2] = 32'h0010_0000;
    send(perm_201, 3'd3, 1'b0);
    chk("perm.load.vld",     64'(bus.rowVld),  64'd0);
    chk("perm.load.inReady", 64'(bus.inReady), 64'd0);
    @(negedge clk);
    chk_row("perm.r0", 48'h4000_0000_0000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_row("perm.r1", 48'h0000_0000_4000, 3'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_row("perm.r2", 48'h0000_4000_0000, 3'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("perm.end.vld",     64'(bus.rowVld),  64'd0);
    chk("perm.end.inReady", 64'(bus.inReady), 64'd1);

    // Rounding, saturation and back-pressure on row 1
    m = '0;
    m[0][0] = 32'h0000_0060;
    m[0][1] = 32'hFFFF_FFA0;
    m[0][2] = 32'h001F_FFC0;
    m[1][0] = 32'h7FFF_FFFF;
    m[2][0] = 32'h8000_0000;
    send(perm_ident, 3'd3, 1'b0);
    @(negedge clk);
    chk_row("rnd.r0", ROUND_ROW0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_row("sat.r1", 48'h0000_0000_7FFF, 3'd1, 1'b0, 1'b0, 1'b1);
    bus.rowReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_row("bp.hold", 48'h0000_0000_7FFF, 3'd1, 1'b0, 1'b0, 1'b1);
    end
    bus.rowReady = 1'b1;
    @(negedge clk);
    chk_row("sat.r2", 48'h0000_0000_8000, 3'd2, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk("sat.end.vld", 64'(bus.rowVld), 64'd0);

    // Intermediate pass is ignored
    send(perm_ident, 3'd2, 1'b0);
    chk("filt.vld",     64'(bus.rowVld),  64'd0);
    chk("filt.inReady", 64'(bus.inReady), 64'd1);
    chk("filt.overrun", 64'(bus.overrun), 64'd0);
    @(negedge clk);
    chk("filt.vld2",    64'(bus.rowVld),  64'd0);

    // Overrun: final-pass matrix during STREAM is dropped
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = 32'((3 * r + c + 1) << 6);
    send(perm_ident, 3'd3, 1'b0);
    @(negedge clk);
    chk_row("ovr.r0", 48'h0003_0002_0001, 3'd0, 1'b0, 1'b0, 1'b0);
    m = {9{32'h0ABC_0000}};
    send(perm_ident, 3'd3, 1'b0);
    chk("ovr.flag", 64'(bus.overrun), 64'd1);
    chk_row("ovr.r1", 48'h0006_0005_0004, 3'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_row("ovr.r2", 48'h0009_0008_0007, 3'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("ovr.end.vld",     64'(bus.rowVld),  64'd0);
    chk("ovr.end.inReady", 64'(bus.inReady), 64'd1);
    @(negedge clk);
    chk("ovr.dropped.vld", 64'(bus.rowVld),  64'd0);
    chk("ovr.sticky",      64'(bus.overrun), 64'd1);

    // Error frame: zero rows, errorOut set, no saturation reported
    m = '0;
    m[1][0] = 32'h7FFF_FFFF;
    m[2][0] = 32'h8000_0000;
    m[0][1] = 32'h0001_0000;
    send(perm_ident, 3'd3, 1'b1);
    for (int r = 0; r < N; r++) begin
      @(negedge clk);
      chk_row("err.row", 48'h0, 3'(r), (r == N - 1), 1'b1, 1'b0);
    end
    @(negedge clk);
    chk("err.end.vld", 64'(bus.rowVld), 64'd0);

    // Reset during row 1
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[r][c] = 32'((3 * r + c + 1) << 6);
    send(perm_ident, 3'd3, 1'b0);
    @(negedge clk);
    chk_row("rsm.r0", 48'h0003_0002_0001, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_row("rsm.r1", 48'h0006_0005_0004, 3'd1, 1'b0, 1'b0, 1'b0);
    bus.rowReady = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rsm.vld",     64'(bus.rowVld),   64'd0);
    chk("rsm.inReady", 64'(bus.inReady),  64'd1);
    chk("rsm.rowOut",  64'(bus.rowOut),   64'd0);
    chk("rsm.rowIdx",  64'(bus.rowIdx),   64'd0);
    chk("rsm.errOut",  64'(bus.errorOut), 64'd0);
    chk("rsm.overrun", 64'(bus.overrun),  64'd0);
    reset = 1'b0;
    bus.rowReady = 1'b1;
    @(negedge clk);
    chk("rsm.after.vld", 64'(bus.rowVld), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
